// File: rtl/i2s_rx_deserializer_pkg.sv
// rtl/i2s_rx_deserializer_pkg.sv - shared I2S constants and receive FSM state type
package i2s_pkg;

  // Default captured bits per channel, shared with the transmit-side blocks.
  localparam int I2S_SAMPLE_W = 16;

  // Default synchronizer depth for pins coming from the codec.
  localparam int I2S_SYNC_STAGES = 2;

  // Receive framing state: hunting for a left slot, or inside a left/right slot.
  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_deserializer_if.sv
// rtl/i2s_rx_deserializer_if.sv - PCM pair handshake between deserializer and consumer
interface i2s_rx_deserializer_if
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = I2S_SAMPLE_W
);

  logic                sample_valid;
  logic                sample_ready;
  logic [SAMPLE_W-1:0] left_sample;
  logic [SAMPLE_W-1:0] right_sample;

  // Producer side: the deserializer offers a left/right pair.
  modport master (
    output sample_valid,
    output left_sample,
    output right_sample,
    input  sample_ready
  );

  // Consumer side: level meter, loopback path, etc.
  modport slave (
    input  sample_valid,
    input  left_sample,
    input  right_sample,
    output sample_ready
  );

endinterface

// File: rtl/i2s_rx_deserializer_pin_sync.sv
// rtl/i2s_rx_deserializer_pin_sync.sv - codec pin synchronizers and bclk rise detector
module i2s_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bclk,
  input  logic lrclk,
  input  logic din,
  output logic rise,
  output logic lrclk_s,
  output logic din_s
);

  logic [STAGES-1:0] bclk_ff;
  logic [STAGES-1:0] lrclk_ff;
  logic [STAGES-1:0] din_ff;
  logic              bclk_prev;

  // Multi-flop chains bringing the asynchronous codec pins into the Clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_ff  <= '0;
      lrclk_ff <= '0;
      din_ff   <= '0;
    end else begin
      bclk_ff  <= {bclk_ff[STAGES-2:0], bclk};
      lrclk_ff <= {lrclk_ff[STAGES-2:0], lrclk};
      din_ff   <= {din_ff[STAGES-2:0], din};
    end
  end

  // Registered rise pulse; lrclk/din get the same extra stage so all three stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_prev <= 1'b0;
      rise      <= 1'b0;
      lrclk_s   <= 1'b0;
      din_s     <= 1'b0;
    end else begin
      bclk_prev <= bclk_ff[STAGES-1];
      rise      <= bclk_ff[STAGES-1] & ~bclk_prev;
      lrclk_s   <= lrclk_ff[STAGES-1];
      din_s     <= din_ff[STAGES-1];
    end
  end

endmodule

// File: rtl/i2s_rx_deserializer.sv
// rtl/i2s_rx_deserializer.sv - I2S receive deserializer producing left/right PCM pairs
module i2s_rx_deserializer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W    = I2S_SAMPLE_W,
  parameter int SYNC_STAGES = I2S_SYNC_STAGES
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         bclk,
  input  logic                         lrclk,
  input  logic                         din,
  input  logic                         enable,
  input  logic                         clear_flags,
  i2s_rx_deserializer_if.master        smp,
  output logic                         aligned,
  output logic                         overrun,
  output logic                         short_word
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);
  localparam int IDX_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_W);

  logic                rise;
  logic                lr_s;
  logic                din_s;

  i2s_rx_state_t       state;
  logic                prev_lr;
  logic [SAMPLE_W-1:0] shift_reg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] left_hold;

  logic                valid_q;
  logic [SAMPLE_W-1:0] left_q;
  logic [SAMPLE_W-1:0] right_q;

  logic                slot_start;
  logic                word_short;
  logic                commit_left;
  logic                pair_done;
  logic                set_short;
  logic                set_overrun;
  logic [IDX_W-1:0]    bit_pos;

  i2s_pin_sync #(
    .STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .bclk    (bclk),
    .lrclk   (lrclk),
    .din     (din),
    .rise    (rise),
    .lrclk_s (lr_s),
    .din_s   (din_s)
  );

  // A slot begins on the first rise that sees word select change.
  assign slot_start  = rise & (lr_s != prev_lr);
  assign word_short  = (bit_cnt < CNT_FULL);
  assign commit_left = enable & slot_start & lr_s & (state == LEFT);
  assign pair_done   = enable & slot_start & ~lr_s & (state == RIGHT);
  assign set_short   = (commit_left | pair_done) & word_short;
  assign set_overrun = pair_done & valid_q & ~smp.sample_ready;
  // Bits land MSB-first so a short slot is already left-justified with zero LSBs.
  assign bit_pos     = IDX_W'(SAMPLE_W - 1) - IDX_W'(bit_cnt);

  // Framing FSM with shifter and bit counter; word select history runs even when disabled.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= SEEK;
      prev_lr   <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      left_hold <= '0;
      aligned   <= 1'b0;
    end else begin
      if (rise) begin
        prev_lr <= lr_s;
      end
      if (!enable) begin
        state     <= SEEK;
        aligned   <= 1'b0;
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (rise) begin
        if (slot_start) begin
          // The data bit on the word-select rise belongs to the previous slot.
          shift_reg <= '0;
          bit_cnt   <= '0;
          case (state)
            SEEK: begin
              if (!lr_s) begin
                state   <= LEFT;
                aligned <= 1'b1;
              end
            end
            LEFT: begin
              if (lr_s) begin
                left_hold <= shift_reg;
                state     <= RIGHT;
              end
            end
            RIGHT: begin
              if (!lr_s) begin
                state <= LEFT;
              end
            end
            default: state <= SEEK;
          endcase
        end else if (word_short) begin
          shift_reg[bit_pos] <= din_s;
          bit_cnt            <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Output pair register: load when empty or being drained, otherwise drop and flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      if (pair_done && (!valid_q || smp.sample_ready)) begin
        valid_q <= 1'b1;
        left_q  <= left_hold;
        right_q <= shift_reg;
      end else if (valid_q && smp.sample_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Sticky status flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      overrun    <= 1'b0;
      short_word <= 1'b0;
    end else begin
      overrun    <= set_overrun | (overrun & ~clear_flags);
      short_word <= set_short | (short_word & ~clear_flags);
    end
  end

  assign smp.sample_valid = valid_q;
  assign smp.left_sample  = left_q;
  assign smp.right_sample = right_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// tb/tb_i2s_rx_deserializer.sv - codec BFM bench with slot-level reference model
module tb_i2s_rx_deserializer;
  import i2s_pkg::*;

  localparam int SW   = I2S_SAMPLE_W;
  localparam int SS   = 2;
  localparam int HALF = 8;

  logic Clk         = 1'b0;
  logic Reset_n     = 1'b0;
  logic bclk        = 1'b0;
  logic lrclk       = 1'b0;
  logic din         = 1'b0;
  logic enable      = 1'b0;
  logic clear_flags = 1'b0;
  logic aligned;
  logic overrun;
  logic short_word;

  logic rand_ready  = 1'b0;
  logic ready_force = 1'b0;

  i2s_rx_deserializer_if #(.SAMPLE_W(SW)) smp ();

  i2s_rx_deserializer #(
    .SAMPLE_W    (SW),
    .SYNC_STAGES (SS)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .din         (din),
    .enable      (enable),
    .clear_flags (clear_flags),
    .smp         (smp),
    .aligned     (aligned),
    .overrun     (overrun),
    .short_word  (short_word)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  pair_t       q[$];
  logic        m_last_ch   = 1'b0;
  logic        m_aligned   = 1'b0;
  logic        m_en        = 1'b0;
  logic        m_lok       = 1'b0;
  logic        m_hold      = 1'b0;
  logic        exp_overrun = 1'b0;
  logic        exp_short   = 1'b0;
  logic [15:0] m_lw        = '0;
  logic [15:0] m_cap       = '0;
  logic        m_cur_short = 1'b0;
  time         last_rise_t = 0;
  int          valid_cycles = 0;

  // Bits that survive a slot of len BCLKs: one-bit delay, then at most SW bits.
  function automatic logic [15:0] captured(input logic [15:0] w, input int len);
    logic [15:0] m;
    int n;
    m = '0;
    n = (len - 1 < SW) ? len - 1 : SW;
    for (int i = 0; i < n; i++) m[SW-1-i] = 1'b1;
    return w & m;
  endfunction

  task automatic publish(input logic [15:0] l, input logic [15:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    if (m_hold && q.size() > 0) exp_overrun = 1'b1;
    else q.push_back(p);
  endtask

  // A slot closes when the next one opens; a left start after a full L,R pair publishes it.
  task automatic model_slot_start(input logic ch, input logic [15:0] w, input int len);
    if (ch != m_last_ch) begin
      if (m_en && m_aligned) begin
        if (m_last_ch == 1'b0) begin
          m_lw  = m_cap;
          m_lok = 1'b1;
          if (m_cur_short) exp_short = 1'b1;
        end else if (m_lok) begin
          if (m_cur_short) exp_short = 1'b1;
          publish(m_lw, m_cap);
          m_lok = 1'b0;
        end
      end
      if (ch == 1'b0 && m_en) m_aligned = 1'b1;
      m_last_ch = ch;
    end
    m_cap       = captured(w, len);
    m_cur_short = (len - 1 < SW);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, smp.sample_valid, 0);
    chk({tag, "_left"}, smp.left_sample, 0);
    chk({tag, "_right"}, smp.right_sample, 0);
    chk({tag, "_aligned"}, aligned, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_short"}, short_word, 0);
  endtask

  task automatic pulse_reset();
    Reset_n     = 1'b0;
    m_aligned   = 1'b0;
    m_lok       = 1'b0;
    exp_overrun = 1'b0;
    exp_short   = 1'b0;
    q.delete();
    @(negedge Clk);
    check_zero("reset_mid");
    Reset_n = 1'b1;
  endtask

  task automatic do_action(input int act);
    if (act == 1) begin
      enable    = 1'b0;
      m_en      = 1'b0;
      m_aligned = 1'b0;
      m_lok     = 1'b0;
    end else if (act == 2) begin
      enable = 1'b1;
      m_en   = 1'b1;
    end else if (act == 3) begin
      pulse_reset();
    end
  endtask

  // Codec BFM: word select and data change on BCLK fall, MSB one BCLK after the LRCLK edge.
  task automatic send_slot(input logic ch, input logic [15:0] w, input int len, input int act);
    for (int i = 0; i < len; i++) begin
      @(negedge Clk);
      bclk  = 1'b0;
      lrclk = ch;
      if (i == 0) begin
        din = 1'($urandom);
        model_slot_start(ch, w, len);
      end else if (i - 1 < SW) begin
        din = w[SW-i];
      end else begin
        din = 1'($urandom);
      end
      if (i == len / 2 && act != 0) do_action(act);
      repeat (HALF) @(negedge Clk);
      bclk = 1'b1;
      if (i == 0 && ch == 1'b0) last_rise_t = $time;
      repeat (HALF - 1) @(negedge Clk);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge Clk);
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic pulse_clear();
    @(negedge Clk);
    clear_flags = 1'b1;
    @(negedge Clk);
    clear_flags = 1'b0;
    exp_overrun = 1'b0;
    exp_short   = 1'b0;
    @(negedge Clk);
  endtask

  function automatic logic [15:0] rnd16();
    return 16'($urandom);
  endfunction

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      smp.sample_ready = rand_ready ? 1'($urandom) : ready_force;
    end
  end

  logic v_prev = 1'b0;
  always @(negedge Clk) begin
    if (smp.sample_valid && !v_prev)
      chk("latency", 32'(($time - last_rise_t) / 10), SS + 2);
    if (smp.sample_valid) valid_cycles++;
    if (smp.sample_valid && smp.sample_ready) begin
      if (q.size() == 0) begin
        chk("spurious_pair", 1, 0);
      end else begin
        chk("pair_left", smp.left_sample, q[0].l);
        chk("pair_right", smp.right_sample, q[0].r);
        void'(q.pop_front());
      end
    end
    v_prev = smp.sample_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lens[4];
    logic [15:0] l6;
    lens = '{32, 24, 16, 14};

    repeat (4) @(negedge Clk);
    check_zero("reset");
    Reset_n     = 1'b1;
    enable      = 1'b1;
    m_en        = 1'b1;
    ready_force = 1'b1;
    repeat (4) @(negedge Clk);

    // basic pair
    valid_cycles = 0;
    send_slot(1'b1, 16'h0F0F, 32, 0);
    send_slot(1'b0, 16'h1234, 32, 0);
    send_slot(1'b1, 16'hABCD, 32, 0);
    send_slot(1'b0, 16'h5555, 32, 0);
    wait_drain();
    chk("t1_valid_cycles", valid_cycles, 1);
    chk("t1_left", smp.left_sample, 16'h1234);
    chk("t1_right", smp.right_sample, 16'hABCD);
    chk("t1_aligned", aligned, 1);
    chk("t1_overrun", overrun, 0);

    // stream joins mid right slot
    pulse_reset();
    send_slot(1'b1, rnd16(), 10, 0);
    chk("t2_not_aligned", aligned, 0);
    send_slot(1'b0, rnd16(), 32, 0);
    chk("t2_aligned", aligned, 1);
    send_slot(1'b1, rnd16(), 32, 0);
    send_slot(1'b0, rnd16(), 32, 0);
    send_slot(1'b1, rnd16(), 32, 0);
    send_slot(1'b0, rnd16(), 32, 0);
    wait_drain();

    // consumer stalls for three frames
    send_slot(1'b1, rnd16(), 32, 0);
    send_slot(1'b0, 16'h8001, 32, 0);
    wait_drain();
    m_hold      = 1'b1;
    ready_force = 1'b0;
    send_slot(1'b1, 16'h7FFF, 32, 0);
    send_slot(1'b0, rnd16(), 32, 0);
    send_slot(1'b1, rnd16(), 32, 0);
    send_slot(1'b0, rnd16(), 32, 0);
    send_slot(1'b1, rnd16(), 32, 0);
    send_slot(1'b0, rnd16(), 32, 0);
    repeat (8) @(negedge Clk);
    chk("t3_valid", smp.sample_valid, 1);
    chk("t3_left", smp.left_sample, 16'h8001);
    chk("t3_right", smp.right_sample, 16'h7FFF);
    chk("t3_overrun", overrun, exp_overrun);
    chk("t3_pending", q.size(), 1);
    pulse_clear();
    chk("t3_overrun_clr", overrun, 0);
    chk("t3_valid_hold", smp.sample_valid, 1);
    m_hold      = 1'b0;
    ready_force = 1'b1;
    wait_drain();
    send_slot(1'b1, 16'h2468, 32, 0);
    send_slot(1'b0, rnd16(), 32, 0);
    wait_drain();
    chk("t3_next_right", smp.right_sample, 16'h2468);
    chk("t3_overrun_end", overrun, 0);

    // 12-BCLK slots
    send_slot(1'b1, rnd16(), 32, 0);
    send_slot(1'b0, 16'hABC0, 12, 0);
    send_slot(1'b1, 16'h5A5A, 12, 0);
    send_slot(1'b0, rnd16(), 32, 0);
    wait_drain();
    chk("t4_left", smp.left_sample, 16'hABC0);
    chk("t4_right", smp.right_sample, 16'h5A40);
    chk("t4_short", short_word, exp_short);
    pulse_clear();
    chk("t4_short_clr", short_word, 0);

    // reset in the middle of a left slot
    send_slot(1'b1, rnd16(), 32, 0);
    send_slot(1'b0, rnd16(), 32, 3);
    valid_cycles = 0;
    send_slot(1'b1, rnd16(), 32, 0);
    chk("t5_not_aligned", aligned, 0);
    chk("t5_no_valid", valid_cycles, 0);
    send_slot(1'b0, rnd16(), 32, 0);
    send_slot(1'b1, rnd16(), 32, 0);
    send_slot(1'b0, rnd16(), 32, 0);
    wait_drain();
    chk("t5_aligned", aligned, 1);

    // enable dropped mid frame, restored two frames later
    send_slot(1'b1, rnd16(), 32, 0);
    send_slot(1'b0, rnd16(), 32, 0);
    send_slot(1'b1, rnd16(), 32, 1);
    chk("t6_disabled", aligned, 0);
    send_slot(1'b0, rnd16(), 32, 0);
    send_slot(1'b1, rnd16(), 32, 0);
    send_slot(1'b0, rnd16(), 32, 0);
    send_slot(1'b1, rnd16(), 32, 2);
    chk("t6_not_yet", aligned, 0);
    l6 = rnd16();
    send_slot(1'b0, l6, 32, 0);
    send_slot(1'b1, rnd16(), 32, 0);
    send_slot(1'b0, rnd16(), 32, 0);
    wait_drain();
    chk("t6_left", smp.left_sample, l6);

    // random words, slot lengths and consumer readiness
    rand_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      send_slot(1'b1, rnd16(), lens[$urandom_range(0, 3)], 0);
      send_slot(1'b0, rnd16(), lens[$urandom_range(0, 3)], 0);
    end
    send_slot(1'b1, rnd16(), 32, 0);
    send_slot(1'b0, rnd16(), 32, 0);
    wait_drain();
    rand_ready = 1'b0;
    chk("t7_short", short_word, exp_short);
    chk("t7_overrun", overrun, exp_overrun);
    chk("end_queue", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
